vec_forward_unit: RTL and testbench

- Parametrised successor of the scalar EX/WB operand forwarder.
- Generalised to NUM_SRC operand ports of DATA_W bits (vector lanes), with per-source use enables.
- Adds a third forward path from load return data, plus a load-use stall FSM with a wait counter and timeout.
- Sits between the register-file read stage and the EX stage of the vector ASIP pipeline; drives forwarded operands and a pipeline stall.

---
 rtl/vfwd_pkg.sv | 21 ++
 rtl/vfwd_operand_mux.sv | 56 +++++
 rtl/vec_forward_unit.sv | 140 ++++++++++++++
 tb/tb_vec_forward_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfwd_pkg.sv
// Shared types and defaults for the vector operand forwarder.
// Latency: none (types only). Backpressure: none (types only).
// Path-select and FSM encodings are visible to both the top and the operand mux.
package vfwd_pkg;

    localparam int VFWD_DATA_W = 256;
    localparam int VFWD_REG_AW = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_WB = 2'd1,
        FWD_LD = 2'd2,
        FWD_EX = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fsm_e;

endpackage

// File: rtl/vfwd_operand_mux.sv
// One source operand: priority match EX > LD > WB > RF, plus per-source load-use hazard.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; hazard feeds the stall FSM in the top.
module vfwd_operand_mux
    import vfwd_pkg::*;
#(
    parameter int DATA_W = VFWD_DATA_W,
    parameter int REG_AW = VFWD_REG_AW
) (
    input  logic [REG_AW-1:0] addr,
    input  logic              use_en,
    input  logic [DATA_W-1:0] rf_dat,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_wen,
    input  logic [DATA_W-1:0] wb_res,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] op_dat,
    output fwd_sel_e          sel,
    output logic              hazard
);

    logic live;
    logic ex_hit;
    logic ld_hit;
    logic wb_hit;

    // Register 0 is hard-zero, so it never matches any producer.
    assign live   = use_en && (addr != '0);
    assign ex_hit = live && ex_wen && !ex_is_load && (addr == ex_dest);
    assign ld_hit = live && ld_valid && (addr == ld_dest);
    assign wb_hit = live && wb_wen && (addr == wb_dest);

    assign hazard = live && ex_wen && ex_is_load && (addr == ex_dest) && !ld_hit;

    always_comb begin
        sel    = FWD_RF;
        op_dat = rf_dat;
        if (ex_hit) begin
            sel    = FWD_EX;
            op_dat = ex_res;
        end else if (ld_hit) begin
            sel    = FWD_LD;
            op_dat = ld_data;
        end else if (wb_hit) begin
            sel    = FWD_WB;
            op_dat = wb_res;
        end
    end

endmodule

// File: rtl/vec_forward_unit.sv
// Vector operand forwarder (EX/LD/WB/RF) with load-use stall FSM; FWD_PERF_EN adds perf counters.
// Latency: 0 cycles for forwarding; load-use stall lasts until the load returns or times out.
// Backpressure: stall freezes decode and bubbles EX; wait_err flags a timed-out load (sticky).
module vec_forward_unit
    import vfwd_pkg::*;
#(
    parameter int DATA_W   = VFWD_DATA_W,
    parameter int REG_AW   = VFWD_REG_AW,
    parameter int NUM_SRC  = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_use,
    input  logic [NUM_SRC*DATA_W-1:0] src_rf,
    input  logic [REG_AW-1:0]         ex_dest,
    input  logic                      ex_wen,
    input  logic                      ex_is_load,
    input  logic [DATA_W-1:0]         ex_res,
    input  logic [REG_AW-1:0]         wb_dest,
    input  logic                      wb_wen,
    input  logic [DATA_W-1:0]         wb_res,
    input  logic                      ld_valid,
    input  logic [REG_AW-1:0]         ld_dest,
    input  logic [DATA_W-1:0]         ld_data,
    output logic [NUM_SRC*DATA_W-1:0] src_out,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall,
`ifdef FWD_PERF_EN
    output logic                      wait_err,
    output logic [31:0]               fwd_cnt,
    output logic [31:0]               stall_cnt
`else
    output logic                      wait_err
`endif
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    fsm_e               state;
    logic [REG_AW-1:0]  pend_dest;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SRC-1:0] src_hazard;
    fwd_sel_e           sel_arr [NUM_SRC];
    logic               hazard;
    logic               ld_ret;
    logic               timeout;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        vfwd_operand_mux #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_mux (
            .addr       (src_addr[gi*REG_AW +: REG_AW]),
            .use_en     (src_use[gi]),
            .rf_dat     (src_rf[gi*DATA_W +: DATA_W]),
            .ex_dest    (ex_dest),
            .ex_wen     (ex_wen),
            .ex_is_load (ex_is_load),
            .ex_res     (ex_res),
            .wb_dest    (wb_dest),
            .wb_wen     (wb_wen),
            .wb_res     (wb_res),
            .ld_valid   (ld_valid),
            .ld_dest    (ld_dest),
            .ld_data    (ld_data),
            .op_dat     (src_out[gi*DATA_W +: DATA_W]),
            .sel        (sel_arr[gi]),
            .hazard     (src_hazard[gi])
        );
        assign fwd_sel[gi*2 +: 2] = sel_arr[gi];
    end

    assign hazard = |src_hazard;
    assign ld_ret = ld_valid && (ld_dest == pend_dest);
    // Entry into WAIT already accounts for one stall cycle, so give up one short of MAX_WAIT.
    assign timeout = (cnt >= CNT_W'(MAX_WAIT - 1));

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = hazard;
            WAIT:    stall = !ld_ret;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_dest <= '0;
            cnt       <= '0;
            wait_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        pend_dest <= ex_dest;
                        cnt       <= CNT_W'(1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (ld_ret) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != CNT_W'(MAX_WAIT)) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (timeout) begin
                            wait_err <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FWD_PERF_EN
    logic [NUM_SRC-1:0] src_fwd;

    for (genvar gp = 0; gp < NUM_SRC; gp++) begin : g_perf
        assign src_fwd[gp] = (sel_arr[gp] != FWD_RF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (|src_fwd) fwd_cnt <= fwd_cnt + 32'd1;
            if (stall) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_forward_unit.sv
// Directed bench for vec_forward_unit: forwarding priority, load-use stall, timeout, async reset.
module tb_vec_forward_unit;

    localparam int DW = 256;
    localparam int AW = 4;
    localparam int NS = 3;

    localparam logic [DW-1:0] RF0  = {8{32'h1111_0000}};
    localparam logic [DW-1:0] RF1  = {8{32'h2222_0001}};
    localparam logic [DW-1:0] RF2  = {8{32'h3333_0002}};
    localparam logic [DW-1:0] EX_V = {8{32'hE0E0_0003}};
    localparam logic [DW-1:0] WB_V = {8{32'hB0B0_0004}};
    localparam logic [DW-1:0] LD_V = {8{32'hD0D0_0005}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*AW-1:0]  src_addr;
    logic [NS-1:0]     src_use;
    logic [NS*DW-1:0]  src_rf;
    logic [AW-1:0]     ex_dest;
    logic              ex_wen;
    logic              ex_is_load;
    logic [DW-1:0]     ex_res;
    logic [AW-1:0]     wb_dest;
    logic              wb_wen;
    logic [DW-1:0]     wb_res;
    logic              ld_valid;
    logic [AW-1:0]     ld_dest;
    logic [DW-1:0]     ld_data;
    logic [NS*DW-1:0]  src_out;
    logic [NS*2-1:0]   fwd_sel;
    logic              stall;
    logic              wait_err;
`ifdef FWD_PERF_EN
    logic [31:0]       fwd_cnt;
    logic [31:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_forward_unit #(
        .DATA_W   (DW),
        .REG_AW   (AW),
        .NUM_SRC  (NS),
        .MAX_WAIT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_addr   (src_addr),
        .src_use    (src_use),
        .src_rf     (src_rf),
        .ex_dest    (ex_dest),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .ex_res     (ex_res),
        .wb_dest    (wb_dest),
        .wb_wen     (wb_wen),
        .wb_res     (wb_res),
        .ld_valid   (ld_valid),
        .ld_dest    (ld_dest),
        .ld_data    (ld_data),
        .src_out    (src_out),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .wait_err   (wait_err)
`ifdef FWD_PERF_EN
        , .fwd_cnt  (fwd_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic clear_inputs();
        src_addr   = '0;
        src_use    = '0;
        src_rf     = {RF2, RF1, RF0};
        ex_dest    = '0;
        ex_wen     = 1'b0;
        ex_is_load = 1'b0;
        ex_res     = EX_V;
        wb_dest    = '0;
        wb_wen     = 1'b0;
        wb_res     = WB_V;
        ld_valid   = 1'b0;
        ld_dest    = '0;
        ld_data    = LD_V;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++;
        if (wait_err !== 1'b0) begin errors++; $display("FAIL reset_wait_err got %b exp 0", wait_err); end
        checks++;
        if (fwd_sel !== 6'b000000) begin errors++; $display("FAIL reset_fwd_sel got %b exp 000000", fwd_sel); end
        checks++;
        if (src_out !== {RF2, RF1, RF0}) begin errors++; $display("FAIL reset_src_out got %h", src_out[DW-1:0]); end
`ifdef FWD_PERF_EN
        checks++;
        if (fwd_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", fwd_cnt, stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        @(negedge clk);
        clear_inputs();
        src_addr[0 +: AW] = 4'd5;
        src_use[0] = 1'b1;
        ex_dest = 4'd5; ex_wen = 1'b1;
        wb_dest = 4'd5; wb_wen = 1'b1;
        ld_dest = 4'd5; ld_valid = 1'b1;
        #1;
        checks++;
        if (src_out[0 +: DW] !== EX_V) begin errors++; $display("FAIL prio_ex_dat got %h exp %h", src_out[0 +: DW], EX_V); end
        checks++;
        if (fwd_sel[1:0] !== 2'd3) begin errors++; $display("FAIL prio_ex_sel got %0d exp 3", fwd_sel[1:0]); end
        ex_wen = 1'b0;
        #1;
        checks++;
        if (src_out[0 +: DW] !== LD_V || fwd_sel[1:0] !== 2'd2) begin
            errors++; $display("FAIL prio_ld got sel %0d exp 2", fwd_sel[1:0]);
        end
        ld_valid = 1'b0;
        #1;
        checks++;
        if (src_out[0 +: DW] !== WB_V || fwd_sel[1:0] !== 2'd1) begin
            errors++; $display("FAIL prio_wb got sel %0d exp 1", fwd_sel[1:0]);
        end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got %b exp 0", stall); end
    endtask

    task automatic test_zero_and_use();
        @(negedge clk);
        clear_inputs();
        src_addr[0 +: AW]    = 4'd5; src_use[0] = 1'b1;
        src_addr[AW +: AW]   = 4'd0; src_use[1] = 1'b1;
        src_addr[2*AW +: AW] = 4'd5; src_use[2] = 1'b0;
        ex_dest = 4'd5; ex_wen = 1'b1;
        #1;
        checks++;
        if (fwd_sel !== 6'b000011) begin errors++; $display("FAIL use_gate_sel got %b exp 000011", fwd_sel); end
        checks++;
        if (src_out[2*DW +: DW] !== RF2) begin errors++; $display("FAIL use_gate_dat got %h exp %h", src_out[2*DW +: DW], RF2); end
        ex_dest = 4'd0;
        wb_dest = 4'd0; wb_wen = 1'b1;
        #1;
        checks++;
        if (src_out[DW +: DW] !== RF1 || fwd_sel[3:2] !== 2'd0) begin
            errors++; $display("FAIL zero_reg got sel %0d exp 0", fwd_sel[3:2]);
        end
    endtask

    task automatic test_load_use();
        int stall_cycles = 0;
        @(negedge clk);
        clear_inputs();
        src_addr[0 +: AW] = 4'd7; src_use[0] = 1'b1;
        ex_dest = 4'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
        #1;
        if (stall) stall_cycles++;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            ex_wen = 1'b0; ex_is_load = 1'b0;
            #1;
            if (stall) stall_cycles++;
        end
        @(negedge clk);
        ld_valid = 1'b1; ld_dest = 4'd7;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL ld_use_return_stall got %b exp 0", stall); end
        checks++;
        if (src_out[0 +: DW] !== LD_V || fwd_sel[1:0] !== 2'd2) begin
            errors++; $display("FAIL ld_use_return_fwd got sel %0d exp 2", fwd_sel[1:0]);
        end
        checks++;
        if (stall_cycles != 3) begin errors++; $display("FAIL ld_use_stall_len got %0d exp 3", stall_cycles); end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL ld_use_after got %b exp 0", stall); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        clear_inputs();
        src_addr[0 +: AW] = 4'd7; src_use[0] = 1'b1;
        ex_dest = 4'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
        ld_valid = 1'b1; ld_dest = 4'd7;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL same_cycle_stall got %b exp 0", stall); end
        checks++;
        if (src_out[0 +: DW] !== LD_V || fwd_sel[1:0] !== 2'd2) begin
            errors++; $display("FAIL same_cycle_fwd got sel %0d exp 2", fwd_sel[1:0]);
        end
        @(negedge clk);
        ex_wen = 1'b0; ex_is_load = 1'b0; ld_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL same_cycle_next got %b exp 0", stall); end
    endtask

    task automatic test_other_ld_in_wait();
        @(negedge clk);
        clear_inputs();
        src_addr[0 +: AW]  = 4'd7; src_use[0] = 1'b1;
        src_addr[AW +: AW] = 4'd9; src_use[1] = 1'b1;
        ex_dest = 4'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
        @(negedge clk);
        ex_wen = 1'b0; ex_is_load = 1'b0;
        ld_valid = 1'b1; ld_dest = 4'd9;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL other_ld_stall got %b exp 1", stall); end
        checks++;
        if (src_out[DW +: DW] !== LD_V || fwd_sel[3:2] !== 2'd2) begin
            errors++; $display("FAIL other_ld_fwd got sel %0d exp 2", fwd_sel[3:2]);
        end
        @(negedge clk);
        ld_dest = 4'd7;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL other_ld_release got %b exp 0", stall); end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int stall_cycles = 0;
        @(negedge clk);
        clear_inputs();
        src_addr[0 +: AW] = 4'd7; src_use[0] = 1'b1;
        ex_dest = 4'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
        wb_dest = 4'd7; wb_wen = 1'b1;
        #1;
        if (stall) stall_cycles++;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            ex_wen = 1'b0; ex_is_load = 1'b0;
            #1;
            if (stall) stall_cycles++;
        end
        checks++;
        if (stall_cycles != 15) begin errors++; $display("FAIL timeout_stall_len got %0d exp 15", stall_cycles); end
        checks++;
        if (wait_err !== 1'b1) begin errors++; $display("FAIL timeout_wait_err got %b exp 1", wait_err); end
        checks++;
        if (src_out[0 +: DW] !== WB_V || fwd_sel[1:0] !== 2'd1) begin
            errors++; $display("FAIL timeout_wb_path got sel %0d exp 1", fwd_sel[1:0]);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wait_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", wait_err); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        clear_inputs();
        src_addr[0 +: AW] = 4'd7; src_use[0] = 1'b1;
        ex_dest = 4'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
        @(negedge clk);
        ex_wen = 1'b0; ex_is_load = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL midwait_pre_stall got %b exp 1", stall); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL midwait_async_stall got %b exp 0", stall); end
        checks++;
        if (wait_err !== 1'b0) begin errors++; $display("FAIL midwait_async_err got %b exp 0", wait_err); end
`ifdef FWD_PERF_EN
        checks++;
        if (fwd_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL midwait_perf got %0d/%0d exp 0/0", fwd_cnt, stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL midwait_idle got %b exp 0", stall); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_zero_and_use();
        test_load_use();
        test_same_cycle();
        test_other_ld_in_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
